// File: rtl/vedic_mult_pipe_if.sv
// Valid/ready operand and product stream for vedic_mult_pipe.
// in_signed exists only when VEDIC_MULT_SIGNED_EN is defined.
interface vedic_mult_pipe_if #(
    parameter int unsigned N = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     a;
    logic [N-1:0]     b;
`ifdef VEDIC_MULT_SIGNED_EN
    logic             in_signed;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   product;
    logic             busy;

`ifdef VEDIC_MULT_SIGNED_EN
    modport master (
        output in_valid, a, b, in_signed, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, a, b, in_signed, out_ready,
        output in_ready, out_valid, product, busy
    );
`else
    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );
    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
`endif
endinterface

// File: rtl/vedic_mult_pipe.sv
// Three-stage pipelined Urdhva-Tiryagbhyam multiplier with valid/ready flow control.
// Define VEDIC_MULT_SIGNED_EN to add the per-transaction two's-complement mode.
module vedic_mult_pipe #(
    parameter int unsigned N = 32
) (
    input  logic            clk,
    input  logic            rst,
    vedic_mult_pipe_if.slave bus
);
    localparam int unsigned H  = N / 2;
    localparam int unsigned PW = 2 * N;

    logic          adv;
    logic [N-1:0]  mag_a;
    logic [N-1:0]  mag_b;
    logic [N-1:0]  ll_c;
    logic [N-1:0]  hl_c;
    logic [N-1:0]  lh_c;
    logic [N-1:0]  hh_c;
    logic [PW-1:0] sum_c;
    logic [PW-1:0] result_c;

    logic          v1;
    logic [N-1:0]  pp_ll;
    logic [N-1:0]  pp_hl;
    logic [N-1:0]  pp_lh;
    logic [N-1:0]  pp_hh;
    logic          v2;
    logic [N:0]    mid;
    logic [N-1:0]  ll2;
    logic [N-1:0]  hh2;
    logic          out_valid_q;
    logic [PW-1:0] product_q;

    // A single advance enable stalls every stage together, so bubbles keep their slot.
    assign adv           = !out_valid_q || bus.out_ready;
    assign bus.in_ready  = adv && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.product   = product_q;
    assign bus.busy      = v1 || v2 || out_valid_q;

`ifdef VEDIC_MULT_SIGNED_EN
    logic s_in;
    logic s1;
    logic s2;

    // Magnitudes feed the unsigned tree; -2^(N-1) negates to itself, which is its magnitude.
    assign mag_a    = (bus.in_signed && bus.a[N-1]) ? N'(-bus.a) : bus.a;
    assign mag_b    = (bus.in_signed && bus.b[N-1]) ? N'(-bus.b) : bus.b;
    assign s_in     = bus.in_signed && (bus.a[N-1] ^ bus.b[N-1]);
    assign result_c = s2 ? PW'(-sum_c) : sum_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else if (adv) begin
            s1 <= s_in;
            s2 <= s1;
        end
    end
`else
    assign mag_a    = bus.a;
    assign mag_b    = bus.b;
    assign result_c = sum_c;
`endif

    vedic_mult_pipe_tree #(.W(H)) u_ll (.x(mag_a[H-1:0]), .y(mag_b[H-1:0]), .p(ll_c));
    vedic_mult_pipe_tree #(.W(H)) u_hl (.x(mag_a[N-1:H]), .y(mag_b[H-1:0]), .p(hl_c));
    vedic_mult_pipe_tree #(.W(H)) u_lh (.x(mag_a[H-1:0]), .y(mag_b[N-1:H]), .p(lh_c));
    vedic_mult_pipe_tree #(.W(H)) u_hh (.x(mag_a[N-1:H]), .y(mag_b[N-1:H]), .p(hh_c));

    assign sum_c = {hh2, ll2} + (PW'(mid) << H);

    // S1 partial products, S2 cross-term sum with carry, S3 final add and sign fix-up.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1          <= 1'b0;
            pp_ll       <= '0;
            pp_hl       <= '0;
            pp_lh       <= '0;
            pp_hh       <= '0;
            v2          <= 1'b0;
            mid         <= '0;
            ll2         <= '0;
            hh2         <= '0;
            out_valid_q <= 1'b0;
            product_q   <= '0;
        end else if (adv) begin
            v1          <= bus.in_valid;
            pp_ll       <= ll_c;
            pp_hl       <= hl_c;
            pp_lh       <= lh_c;
            pp_hh       <= hh_c;
            v2          <= v1;
            mid         <= {1'b0, pp_hl} + {1'b0, pp_lh};
            ll2         <= pp_ll;
            hh2         <= pp_hh;
            out_valid_q <= v2;
            // Bubbles leave the previous product in place.
            if (v2) begin
                product_q <= result_c;
            end
        end
    end
endmodule

// Recursive combinational Vedic multiplier: W x W -> 2W, built from 2x2 leaves.
module vedic_mult_pipe_tree #(
    parameter int unsigned W = 16
) (
    input  logic [W-1:0]   x,
    input  logic [W-1:0]   y,
    output logic [2*W-1:0] p
);
    if (W == 1) begin : g_bit
        assign p = {1'b0, x & y};
    end else if (W == 2) begin : g_leaf
        logic t0;
        logic t1;
        logic c1;
        logic hh;
        assign t0 = x[1] & y[0];
        assign t1 = x[0] & y[1];
        assign c1 = t0 & t1;
        assign hh = x[1] & y[1];
        assign p  = {hh & c1, hh ^ c1, t0 ^ t1, x[0] & y[0]};
    end else begin : g_node
        localparam int unsigned HW = W / 2;
        logic [W-1:0] ll;
        logic [W-1:0] hl;
        logic [W-1:0] lh;
        logic [W-1:0] hh;
        logic [W:0]   mid;

        vedic_mult_pipe_tree #(.W(HW)) u_ll (.x(x[HW-1:0]), .y(y[HW-1:0]), .p(ll));
        vedic_mult_pipe_tree #(.W(HW)) u_hl (.x(x[W-1:HW]), .y(y[HW-1:0]), .p(hl));
        vedic_mult_pipe_tree #(.W(HW)) u_lh (.x(x[HW-1:0]), .y(y[W-1:HW]), .p(lh));
        vedic_mult_pipe_tree #(.W(HW)) u_hh (.x(x[W-1:HW]), .y(y[W-1:HW]), .p(hh));

        assign mid = {1'b0, hl} + {1'b0, lh};
        assign p   = {hh, ll} + ((2 * W)'(mid) << HW);
    end
endmodule

// File: tb/tb_vedic_mult_pipe.sv
// Directed testbench for vedic_mult_pipe (N=32 plus an 8/16/64 width sweep).
// Signed-mode vectors are exercised only when VEDIC_MULT_SIGNED_EN is defined.
module tb_vedic_mult_pipe;
    localparam int unsigned N  = 32;
    localparam int unsigned PW = 2 * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    vedic_mult_pipe_if #(.N(N))  bus ();
    vedic_mult_pipe_if #(.N(8))  bus8 ();
    vedic_mult_pipe_if #(.N(16)) bus16 ();
    vedic_mult_pipe_if #(.N(64)) bus64 ();

    vedic_mult_pipe #(.N(N))  dut   (.clk(clk), .rst(rst), .bus(bus.slave));
    vedic_mult_pipe #(.N(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8.slave));
    vedic_mult_pipe #(.N(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
    vedic_mult_pipe #(.N(64)) dut64 (.clk(clk), .rst(rst), .bus(bus64.slave));

    function automatic logic [63:0] corner(input int k, input int w);
        logic [63:0] ones;
        ones = '1;
        case (k)
            0:       return 64'd0;
            1:       return 64'd1;
            2:       return ones >> (64 - w);
            default: return 64'd1 << (w - 1);
        endcase
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.product !== 64'd0) begin errors++; $display("FAIL reset_product got %h want 0", bus.product); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", bus.busy); end
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b want 0", bus.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_in_ready got %b want 1", bus.in_ready); end
    endtask

    task automatic test_unsigned();
        logic [N-1:0]  va [6];
        logic [N-1:0]  vb [6];
        logic          vv [6];
        logic [PW-1:0] ve [6];
        logic          want_v;
        va = '{32'hFFFFFFFF, 32'h00001234, 32'h00000000, 32'h00000001, 32'h00010000, 32'h0000FFFF};
        vb = '{32'hFFFFFFFF, 32'h00005678, 32'hDEADBEEF, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF};
        vv = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        // Slot 1 is a bubble: the product must hold the previous result.
        ve = '{64'hFFFFFFFE00000001, 64'hFFFFFFFE00000001, 64'h0, 64'h00000000FFFFFFFF,
               64'h0000000100000000, 64'h00000000FFFE0001};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c < 6) begin
                bus.in_valid = vv[c]; bus.a = va[c]; bus.b = vb[c];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            want_v = (c >= 3 && c < 9) ? vv[c-3] : 1'b0;
            checks++;
            if (bus.out_valid !== want_v) begin errors++; $display("FAIL unsigned_out_valid cycle %0d got %b want %b", c, bus.out_valid, want_v); end
            if (c >= 3 && c < 9) begin
                checks++;
                if (bus.product !== ve[c-3]) begin errors++; $display("FAIL unsigned_product cycle %0d got %h want %h", c, bus.product, ve[c-3]); end
            end
        end
    endtask

`ifdef VEDIC_MULT_SIGNED_EN
    task automatic test_signed();
        logic [N-1:0]  va [5];
        logic [N-1:0]  vb [5];
        logic          vs [5];
        logic [PW-1:0] ve [5];
        va = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vb = '{32'h80000000, 32'h00000002, 32'h00000002, 32'hFFFFFFFF, 32'h7FFFFFFF};
        vs = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        ve = '{64'h4000000000000000, 64'hFFFFFFFFFFFFFFFE, 64'h00000001FFFFFFFE,
               64'h0, 64'hC000000080000000};
        bus.out_ready = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            if (c < 5) begin
                bus.in_valid = 1'b1; bus.a = va[c]; bus.b = vb[c]; bus.in_signed = vs[c];
            end else begin
                bus.in_valid = 1'b0; bus.in_signed = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (c >= 3 && c < 8)) begin errors++; $display("FAIL signed_out_valid cycle %0d got %b", c, bus.out_valid); end
            if (c >= 3 && c < 8) begin
                checks++;
                if (bus.product !== ve[c-3]) begin errors++; $display("FAIL signed_product cycle %0d got %h want %h", c, bus.product, ve[c-3]); end
            end
        end
    endtask
`endif

    task automatic test_streaming();
        logic [PW-1:0] ex [100];
        logic [N-1:0]  ra;
        logic [N-1:0]  rb;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 104; c++) begin
            @(posedge clk); #1;
            if (c < 100) begin
                ra = $urandom(); rb = $urandom();
                ex[c] = PW'(ra) * PW'(rb);
                bus.in_valid = 1'b1; bus.a = ra; bus.b = rb;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            if (c < 100) begin
                checks++;
                if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stream_in_ready cycle %0d got %b want 1", c, bus.in_ready); end
            end
            checks++;
            if (bus.out_valid !== (c >= 3 && c < 103)) begin errors++; $display("FAIL stream_out_valid cycle %0d got %b", c, bus.out_valid); end
            if (c >= 3 && c < 103) begin
                checks++;
                if (bus.product !== ex[c-3]) begin errors++; $display("FAIL stream_product idx %0d got %h want %h", c - 3, bus.product, ex[c-3]); end
            end
        end
    endtask

    task automatic test_back_pressure();
        logic [N-1:0]  pa [4];
        logic [N-1:0]  pb [4];
        logic [PW-1:0] pe [4];
        int            sent;
        int            got;
        pa = '{32'd3, 32'hFFFFFFFF, 32'h12345678, 32'h80000000};
        pb = '{32'd5, 32'h00000002, 32'h00000010, 32'h80000000};
        pe = '{64'd15, 64'h00000001FFFFFFFE, 64'h0000000123456780, 64'h4000000000000000};
        sent = 0;
        got  = 0;
        for (int c = 0; c < 15; c++) begin
            @(posedge clk); #1;
            bus.out_ready = (c >= 8);
            if (sent < 4) begin
                bus.in_valid = 1'b1; bus.a = pa[sent]; bus.b = pb[sent];
            end else begin
                bus.in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if (bus.in_ready !== ((c < 3) || (c >= 8))) begin errors++; $display("FAIL bp_in_ready cycle %0d got %b", c, bus.in_ready); end
            checks++;
            if (bus.out_valid !== (c >= 3 && c <= 11)) begin errors++; $display("FAIL bp_out_valid cycle %0d got %b", c, bus.out_valid); end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if (got >= 4) begin
                    errors++; $display("FAIL bp_duplicate cycle %0d got %h want none", c, bus.product);
                end else if (bus.product !== pe[got]) begin
                    errors++; $display("FAIL bp_product idx %0d got %h want %h", got, bus.product, pe[got]);
                end
                if (bus.out_ready) got++;
            end
            if (bus.in_valid && bus.in_ready) sent++;
        end
        checks++;
        if (got !== 4) begin errors++; $display("FAIL bp_count got %0d want 4", got); end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset_mid_stream();
        logic [N-1:0] ma [3];
        logic [N-1:0] mb [3];
        ma = '{32'd7, 32'h0000FFFF, 32'd2};
        mb = '{32'd9, 32'h0000FFFF, 32'd3};
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b1; bus.a = ma[c]; bus.b = mb[c];
        end
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_in_ready got %b want 0", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_full_out_valid got %b want 1", bus.out_valid); end
        @(posedge clk); #1;
        rst = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b1; bus.a = 32'd3; bus.b = 32'd5;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got %b want 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy got %b want 0", bus.busy); end
        checks++; if (bus.product !== 64'd0) begin errors++; $display("FAIL rst_mid_product got %h want 0", bus.product); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready_after got %b want 1", bus.in_ready); end
        for (int c = 1; c < 5; c++) begin
            @(posedge clk); #1;
            bus.in_valid = 1'b0;
            @(negedge clk);
            checks++;
            if (bus.out_valid !== (c == 3)) begin errors++; $display("FAIL rst_mid_stale cycle %0d got %b", c, bus.out_valid); end
            if (c == 3) begin
                checks++;
                if (bus.product !== 64'd15) begin errors++; $display("FAIL rst_mid_new_product got %h want f", bus.product); end
            end
        end
    endtask

    task automatic test_width_sweep();
        int           ka [6];
        int           kb [6];
        logic [15:0]  e8  [6];
        logic [31:0]  e16 [6];
        logic [127:0] e64 [6];
        logic [63:0]  x;
        logic [63:0]  y;
        logic [127:0] f;
        ka = '{0, 1, 2, 3, 3, 2};
        kb = '{2, 2, 2, 3, 2, 1};
        for (int i = 0; i < 6; i++) begin
            x = corner(ka[i], 8);  y = corner(kb[i], 8);  f = {64'd0, x} * {64'd0, y}; e8[i]  = f[15:0];
            x = corner(ka[i], 16); y = corner(kb[i], 16); f = {64'd0, x} * {64'd0, y}; e16[i] = f[31:0];
            x = corner(ka[i], 64); y = corner(kb[i], 64); f = {64'd0, x} * {64'd0, y}; e64[i] = f;
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (c < 6) begin
                x = corner(ka[c], 8);  y = corner(kb[c], 8);
                bus8.in_valid = 1'b1;  bus8.a = x[7:0];   bus8.b = y[7:0];
                x = corner(ka[c], 16); y = corner(kb[c], 16);
                bus16.in_valid = 1'b1; bus16.a = x[15:0]; bus16.b = y[15:0];
                x = corner(ka[c], 64); y = corner(kb[c], 64);
                bus64.in_valid = 1'b1; bus64.a = x;       bus64.b = y;
            end else begin
                bus8.in_valid = 1'b0; bus16.in_valid = 1'b0; bus64.in_valid = 1'b0;
            end
            @(negedge clk);
            checks++;
            if ({bus8.out_valid, bus16.out_valid, bus64.out_valid} !== {3{c >= 3 && c < 9}}) begin
                errors++; $display("FAIL sweep_out_valid cycle %0d got %b%b%b", c, bus8.out_valid, bus16.out_valid, bus64.out_valid);
            end
            if (c >= 3 && c < 9) begin
                checks++; if (bus8.product !== e8[c-3]) begin errors++; $display("FAIL sweep8_product idx %0d got %h want %h", c - 3, bus8.product, e8[c-3]); end
                checks++; if (bus16.product !== e16[c-3]) begin errors++; $display("FAIL sweep16_product idx %0d got %h want %h", c - 3, bus16.product, e16[c-3]); end
                checks++; if (bus64.product !== e64[c-3]) begin errors++; $display("FAIL sweep64_product idx %0d got %h want %h", c - 3, bus64.product, e64[c-3]); end
            end
        end
    endtask

    initial begin
        bus.in_valid = 1'b0;   bus.a = '0;   bus.b = '0;   bus.out_ready = 1'b1;
        bus8.in_valid = 1'b0;  bus8.a = '0;  bus8.b = '0;  bus8.out_ready = 1'b1;
        bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.out_ready = 1'b1;
        bus64.in_valid = 1'b0; bus64.a = '0; bus64.b = '0; bus64.out_ready = 1'b1;
`ifdef VEDIC_MULT_SIGNED_EN
        bus.in_signed = 1'b0; bus8.in_signed = 1'b0; bus16.in_signed = 1'b0; bus64.in_signed = 1'b0;
`endif
        test_reset();
        test_unsigned();
`ifdef VEDIC_MULT_SIGNED_EN
        test_signed();
`endif
        test_streaming();
        test_back_pressure();
        test_reset_mid_stream();
        test_width_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
